// File: rtl/local_ram_ctrl_if.sv
// rtl/local_ram_ctrl_if.sv - CPU-side memory request bus for local_ram_ctrl
//
// Purpose: groups the CPU request/response handshake into one bundle.
// Signals:
//   mem_valid  request valid, held until mem_ready
//   mem_addr   byte address, held while mem_valid
//   mem_wdata  write data
//   mem_wstrb  byte write strobes, 0 means read
//   mem_ready  one-cycle completion pulse
//   mem_rdata  read data, valid with mem_ready on a read
// Modports: master (CPU side), slave (controller side).
`timescale 1ns/1ps
interface local_ram_ctrl_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/local_ram_ctrl.sv
// rtl/local_ram_ctrl.sv - CPU bus to single-port local RAM controller
//
// Purpose: decodes a CPU request against the RAM window
// [BASE_ADDR, BASE_ADDR+4*WORDS), issues a one-cycle RAM write or read
// strobe, and returns a one-cycle mem_ready pulse (write after 1 cycle,
// read after 2 cycles because the RAM read data is registered).
// Parameters:
//   BASE_ADDR  byte base of the window, 4-byte aligned
//   WORDS      RAM depth in 32-bit words, at most 2048
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   bus (slave)                 CPU request/response bus
//   ram_wr, ram_rd              per-byte write enables, read strobe
//   ram_addr, ram_wdata         RAM word address and write data
//   ram_rdata                   RAM read data, one cycle after address
//   stat_rd_cnt, stat_wr_cnt    completed read/write counts
// Optional feature: define LOCAL_RAM_CTRL_STATS_EN to enable the
// completion counters; otherwise both stat ports are tied to 0.
`timescale 1ns/1ps
module local_ram_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          WORDS     = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  local_ram_ctrl_if.slave       bus,
  output logic [3:0]            ram_wr,
  output logic                  ram_rd,
  output logic [10:0]           ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic [31:0]           stat_rd_cnt,
  output logic [31:0]           stat_wr_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  localparam logic [31:0] WINDOW_BYTES = 32'(4 * WORDS);

  state_t      state;
  logic        ready_q;
  logic [31:0] rdata_q;

  // 33-bit subtraction: bit 32 is the borrow, set when mem_addr < BASE_ADDR.
  logic [32:0] offset_full;
  logic [31:0] offset;
  logic        in_range;
  logic        sel;
  logic        is_write;
  logic        issue_wr;
  logic        issue_rd;

  assign offset_full = {1'b0, bus.mem_addr} - {1'b0, BASE_ADDR};
  assign offset      = offset_full[31:0];
  assign in_range    = !offset_full[32] && (offset < WINDOW_BYTES);
  assign sel         = bus.mem_valid && in_range;
  assign is_write    = (bus.mem_wstrb != 4'b0000);

  // RAM strobes exist only in the IDLE cycle that accepts the request;
  // gating with reset keeps a reset cycle from writing the RAM.
  assign issue_wr = (state == IDLE) && sel && is_write && !reset;
  assign issue_rd = (state == IDLE) && sel && !is_write && !reset;

  assign ram_wr    = issue_wr ? bus.mem_wstrb : 4'b0000;
  assign ram_rd    = issue_rd;
  assign ram_addr  = offset[12:2];
  assign ram_wdata = bus.mem_wdata;

  // Reset also suppresses a pulse that was already registered for this cycle.
  assign bus.mem_ready = ready_q && !reset;
  assign bus.mem_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (sel) begin
            if (is_write) begin
              state   <= RESP;
              ready_q <= 1'b1;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // Completes even if mem_valid has dropped.
          rdata_q <= ram_rdata;
          state   <= RESP;
          ready_q <= 1'b1;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef LOCAL_RAM_CTRL_STATS_EN
  logic        resp_is_rd;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  // resp_is_rd remembers the kind of the accepted request so the RESP
  // cycle knows which counter to bump; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_is_rd <= 1'b0;
      rd_cnt     <= 32'h0000_0000;
      wr_cnt     <= 32'h0000_0000;
    end else begin
      if ((state == IDLE) && sel) begin
        resp_is_rd <= !is_write;
      end
      if (state == RESP) begin
        if (resp_is_rd) begin
          rd_cnt <= rd_cnt + 32'd1;
        end else begin
          wr_cnt <= wr_cnt + 32'd1;
        end
      end
    end
  end

  assign stat_rd_cnt = rd_cnt;
  assign stat_wr_cnt = wr_cnt;
`else
  assign stat_rd_cnt = 32'h0000_0000;
  assign stat_wr_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_local_ram_ctrl.sv
// tb/tb_local_ram_ctrl.sv - scoreboard testbench for local_ram_ctrl
`timescale 1ns/1ps
module tb_local_ram_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  ram_wr;
  logic        ram_rd;
  logic [10:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] stat_rd_cnt;
  logic [31:0] stat_wr_cnt;

  local_ram_ctrl_if bus();

  local_ram_ctrl #(
    .BASE_ADDR (32'h0000_0000),
    .WORDS     (256)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .ram_wr      (ram_wr),
    .ram_rd      (ram_rd),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .stat_rd_cnt (stat_rd_cnt),
    .stat_wr_cnt (stat_wr_cnt)
  );

`ifdef LOCAL_RAM_CTRL_STATS_EN
  localparam logic [31:0] EXP_WR_CNT = 32'd3;
  localparam logic [31:0] EXP_RD_CNT = 32'd2;
`else
  localparam logic [31:0] EXP_WR_CNT = 32'd0;
  localparam logic [31:0] EXP_RD_CNT = 32'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read byte-write RAM behind the controller.
  logic [31:0] ram_mem [0:2047];
  initial ram_rdata = 32'h0;
  always @(posedge clk) begin
    if (ram_rd) ram_rdata <= ram_mem[ram_addr];
    for (int b = 0; b < 4; b++)
      if (ram_wr[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          issue;
    int          lat;
    bit          is_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Monitor: every mem_ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got mem_ready=1 expected no response (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ready_latency", 32'(cyc - mon_e.issue), 32'(mon_e.lat));
        if (mon_e.is_rd) chk("mem_rdata", bus.mem_rdata, mon_e.rd);
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0000;
  endtask

  // Issue one request, check the RAM strobes in the issue cycle, queue the
  // expected response and wait (bounded) for mem_ready. mem_valid is left
  // high so a following call starts in the cycle after RESP.
  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input logic [10:0] exp_ra, input logic [31:0] exp_rd, input bit drop);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    bus.mem_wstrb = ws;
    @(negedge clk);
    chk("ram_addr", 32'(ram_addr), 32'(exp_ra));
    if (ws != 4'b0000) begin
      chk("ram_wr_issue", 32'(ram_wr), 32'(ws));
      chk("ram_rd_on_write", 32'(ram_rd), 32'd0);
    end else begin
      chk("ram_rd_issue", 32'(ram_rd), 32'd1);
      chk("ram_wr_on_read", 32'(ram_wr), 32'd0);
    end
    e.issue = cyc;
    e.lat   = (ws != 4'b0000) ? 1 : 2;
    e.is_rd = (ws == 4'b0000);
    e.rd    = exp_rd;
    exp_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (drop) bus.mem_valid = 1'b0;
      @(negedge clk);
      chk("strobes_after_issue", {27'd0, ram_wr, ram_rd}, 32'd0);
      if (bus.mem_ready === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no mem_ready expected pulse within 10 cycles (addr %h)", a);
      exp_q.delete();
    end
  endtask

  logic [31:0] activity;

  initial begin
    reset         = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("reset_mem_rdata", bus.mem_rdata, 32'h0);
    chk("reset_ram_wr", 32'(ram_wr), 32'd0);
    chk("reset_ram_rd", 32'(ram_rd), 32'd0);
    chk("reset_stat_rd", stat_rd_cnt, 32'd0);
    chk("reset_stat_wr", stat_wr_cnt, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Full write, readback, partial-byte write, readback (back-to-back).
    do_req(32'h10, 32'hDEADBEEF, 4'b1111, 11'd4, 32'h0, 1'b0);
    do_req(32'h10, 32'h0,        4'b0000, 11'd4, 32'hDEADBEEF, 1'b0);
    do_req(32'h10, 32'h00AA0000, 4'b0100, 11'd4, 32'h0, 1'b0);
    do_req(32'h10, 32'h0,        4'b0000, 11'd4, 32'hDEAABEEF, 1'b0);
    idle();

    // One past the window: must be ignored completely.
    @(posedge clk); #1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h400;
    bus.mem_wdata = 32'h55555555;
    bus.mem_wstrb = 4'b1111;
    activity = 32'h0;
    repeat (10) begin
      @(negedge clk);
      activity = activity | {27'd0, ram_wr, ram_rd} | {31'd0, bus.mem_ready};
    end
    chk("out_of_range_activity", activity, 32'h0);
    idle();

    // Last word of the window.
    do_req(32'h3FC, 32'h12345678, 4'b1111, 11'd255, 32'h0, 1'b0);
    do_req(32'h3FC, 32'h0,        4'b0000, 11'd255, 32'h12345678, 1'b0);
    idle();
    do_req(32'h400 - 32'h3F0, 32'h0, 4'b0000, 11'd4, 32'hDEAABEEF, 1'b1);
    idle();

    // Reset while the read is in RD_WAIT: no response, rdata cleared.
    @(posedge clk); #1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h3FC;
    bus.mem_wstrb = 4'b0000;
    @(negedge clk);
    chk("abort_ram_rd_issue", 32'(ram_rd), 32'd1);
    @(posedge clk); #1;
    reset         = 1'b1;
    bus.mem_valid = 1'b0;
    @(negedge clk);
    chk("abort_ready_in_reset", 32'(bus.mem_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    activity = 32'h0;
    repeat (4) begin
      @(negedge clk);
      activity = activity | {31'd0, bus.mem_ready};
    end
    chk("abort_no_ready", activity, 32'h0);
    chk("abort_mem_rdata", bus.mem_rdata, 32'h0);
    chk("abort_stat_rd", stat_rd_cnt, 32'd0);
    chk("abort_stat_wr", stat_wr_cnt, 32'd0);

    // 3 writes and 2 reads for the counters.
    do_req(32'h20, 32'h11112222, 4'b1111, 11'd8, 32'h0, 1'b0);
    do_req(32'h24, 32'h33334444, 4'b1111, 11'd9, 32'h0, 1'b0);
    do_req(32'h20, 32'h0,        4'b0000, 11'd8, 32'h11112222, 1'b0);
    do_req(32'h20, 32'h000000AB, 4'b0001, 11'd8, 32'h0, 1'b0);
    do_req(32'h24, 32'h0,        4'b0000, 11'd9, 32'h33334444, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    chk("stat_wr_cnt", stat_wr_cnt, EXP_WR_CNT);
    chk("stat_rd_cnt", stat_rd_cnt, EXP_RD_CNT);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/local_ram_ctrl.md
LOCAL_RAM_CTRL -- requirements
Module: local_ram_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte base address of the RAM window; SHALL be 4-byte aligned.
REQ-002 Parameter WORDS, default 256: RAM depth in 32-bit words; SHALL be at most 2048.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mem_valid  in  1  CPU request valid; held until mem_ready.
REQ-006 mem_addr  in  32  CPU byte address; held while mem_valid.
REQ-007 mem_wdata  in  32  CPU write data.
REQ-008 mem_wstrb  in  4  byte write strobes; 0 = read.
REQ-009 mem_ready  out  1  one-cycle completion pulse.
REQ-010 mem_rdata  out  32  read data, valid when mem_ready is high for a read.
REQ-011 ram_wr  out  4  per-byte RAM write enables.
REQ-012 ram_rd  out  1  RAM read strobe.
REQ-013 ram_addr  out  11  RAM word address.
REQ-014 ram_wdata  out  32  RAM write data.
REQ-015 ram_rdata  in  32  RAM read data; registered, valid one cycle after address.
REQ-016 stat_rd_cnt, stat_wr_cnt  out  32 each  completed read and write counts.

Function
REQ-017 The block SHALL assert sel = mem_valid && BASE_ADDR <= mem_addr < BASE_ADDR+4*WORDS; when sel is low it SHALL ignore the request and keep mem_ready low.
REQ-018 The block SHALL drive ram_addr = (mem_addr-BASE_ADDR)>>2, truncated to 11 bits, and ram_wdata = mem_wdata combinationally.
REQ-019 The FSM SHALL have three states: IDLE, RD_WAIT, RESP.
REQ-020 In IDLE with sel and mem_wstrb!=0, the block SHALL drive ram_wr=mem_wstrb for that cycle only and go to RESP.
REQ-021 In IDLE with sel and mem_wstrb==0, the block SHALL drive ram_rd=1 for that cycle only and go to RD_WAIT.
REQ-022 In RD_WAIT, the block SHALL capture ram_rdata into the mem_rdata register and go to RESP.
REQ-023 In RESP, the block SHALL drive mem_ready=1 and go to IDLE; ram_wr and ram_rd SHALL be 0.
REQ-024 Write latency SHALL be 1 cycle (request at T, mem_ready at T+1); read latency SHALL be 2 cycles (mem_ready at T+2).
REQ-025 ram_wr SHALL be 0 and ram_rd SHALL be 0 in every state other than the IDLE cycle that issues the access.
REQ-026 Back-to-back requests SHALL be accepted; a new request seen in IDLE the cycle after RESP SHALL start immediately.
REQ-027 mem_rdata SHALL hold its last captured value outside RD_WAIT captures; it need not be meaningful after writes.
REQ-028 If mem_valid drops in RD_WAIT or RESP (protocol violation), the transaction SHALL still complete with the mem_ready pulse.
REQ-029 An address at exactly BASE_ADDR+4*WORDS SHALL be out of range, and BASE_ADDR+4*WORDS-4 SHALL be in range.

Reset
REQ-030 Reset SHALL force the state to IDLE and set mem_ready=0, mem_rdata=0, ram_wr=0, ram_rd=0, and both stat counters to 0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no mem_ready pulse and no RAM write in the reset cycle.

Configuration
REQ-032 With macro LOCAL_RAM_CTRL_STATS_EN defined, stat_rd_cnt and stat_wr_cnt SHALL each increment by 1 in the cycle mem_ready pulses for a read or a write respectively, and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-033 Without LOCAL_RAM_CTRL_STATS_EN, both stat ports SHALL be present and tied to 0, with no counter flops.

Verification
REQ-034 Write at 0x10 with wstrb 4'b1111 and wdata 0xDEADBEEF -> ram_wr=4'hF and ram_addr=4 in cycle T, mem_ready at T+1.
REQ-035 Read at 0x10 after the write -> ram_rd at T, mem_ready at T+2 with mem_rdata=0xDEADBEEF.
REQ-036 Write wstrb 4'b0100 with wdata 0x00AA0000 to 0x10, then read -> 0xDEAABEEF.
REQ-037 Request at 0x400 (WORDS=256) -> no ram_wr, no ram_rd, and no mem_ready for 10 cycles; request at 0x3FC -> ram_addr=255.
REQ-038 Reset asserted in RD_WAIT -> state IDLE, no mem_ready pulse, mem_rdata=0.
REQ-039 With LOCAL_RAM_CTRL_STATS_EN, 3 writes and 2 reads -> stat_wr_cnt=3 and stat_rd_cnt=2; without the macro, both read 0.
